// File: rtl/cmos_half_scaler.sv
`default_nettype none
// cmos_half_scaler: 2x2 box-filter decimator for an RGB565 CMOS pixel stream.
// Rev 1.0
module cmos_half_scaler #(
  parameter int SRC_W = 640,
  parameter int SRC_H = 480
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_vsync,
  input  logic        in_href,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_frame_start
);

  localparam int XW    = $clog2(SRC_W + 1);
  localparam int YW    = $clog2(SRC_H + 1);
  localparam int DEPTH = SRC_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [15:0]   pair;
  logic          vsync_d;
  logic          href_d;
  logic          armed;
  logic          vsync_fall;
  logic          href_fall;
  logic          accept;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [5:0]    r6;
  logic [6:0]    g7;
  logic [5:0]    b6;
  logic [18:0]   pair_sum;
  logic [18:0]   mem [DEPTH];
  logic [18:0]   rd_sum;
  logic [18:0]   cur_sum;
  logic          s1_valid;
  logic [6:0]    r7;
  logic [7:0]    g8;
  logic [6:0]    b7;

  assign vsync_fall = vsync_d & ~in_vsync;
  assign href_fall  = href_d & ~in_href;

  // A pixel on the very cycle vsync falls is already inside the new frame.
  assign accept = in_valid & in_href & ~in_vsync & (armed | vsync_fall)
                & (x < XW'(SRC_W)) & (y < YW'(SRC_H));

  assign r6       = {1'b0, pair[4:0]}   + {1'b0, in_data[4:0]};
  assign g7       = {1'b0, pair[10:5]}  + {1'b0, in_data[10:5]};
  assign b6       = {1'b0, pair[15:11]} + {1'b0, in_data[15:11]};
  assign pair_sum = {b6, g7, r6};

  assign addr  = x[AW:1];
  assign wr_en = accept & x[0] & ~y[0];
  assign rd_en = accept & x[0] & y[0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x               <= '0;
      y               <= '0;
      pair            <= '0;
      vsync_d         <= 1'b0;
      href_d          <= 1'b0;
      armed           <= 1'b0;
      out_frame_start <= 1'b0;
    end else begin
      vsync_d         <= in_vsync;
      href_d          <= in_href;
      out_frame_start <= vsync_fall;
      if (vsync_fall) begin
        armed <= 1'b1;
      end
      if (in_vsync) begin
        x    <= '0;
        y    <= '0;
        pair <= '0;
      end else begin
        if (accept) begin
          x <= x + XW'(1);
          if (!x[0]) begin
            pair <= in_data;
          end
        end
        if (href_fall) begin
          x <= '0;
          if ((x != '0) && (y < YW'(SRC_H))) begin
            y <= y + YW'(1);
          end
        end
      end
    end
  end

  // Even rows only write and odd rows only read, so one port suffices.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[addr] <= pair_sum;
    end else if (rd_en) begin
      rd_sum <= mem[addr];
    end
  end

  assign r7 = {1'b0, rd_sum[5:0]}   + {1'b0, cur_sum[5:0]};
  assign g8 = {1'b0, rd_sum[12:6]}  + {1'b0, cur_sum[12:6]};
  assign b7 = {1'b0, rd_sum[18:13]} + {1'b0, cur_sum[18:13]};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid  <= 1'b0;
      cur_sum   <= '0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
    end else begin
      s1_valid  <= rd_en;
      out_valid <= s1_valid;
      if (rd_en) begin
        cur_sum <= pair_sum;
      end
      if (s1_valid) begin
        out_data <= {b7[6:2], g8[7:2], r7[6:2]};
      end
    end
  end

endmodule
`default_nettype wire
